// File: rtl/fcache_ctrl.sv
// ---------------------------------------------------------------------------
// fcache_ctrl -- frame-cache controller.
//
// Saves the whole f-register bank (NREGS words of W bits) onto an internal
// LIFO frame stack on a call, and restores the most recent frame on a return.
// Frames move through a W-bit single-port RAM, one word per cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   save_req     push fcOut onto the stack (sampled in IDLE only)
//   restore_req  pop the top frame into fcIn (sampled in IDLE only)
//   fcOut        live f-register bank, word k = fcOut[W*k +: W]
//   fcIn         restored frame, same layout, registered
//   restore      one-cycle strobe, fcIn valid while high
//   busy         high in SAVE / READ / LOAD
//   done         one-cycle pulse when an accepted request completes
//   overflow     sticky: save attempted with the stack full
//   underflow    sticky: restore attempted with the stack empty
//   depth        number of frames currently stored
// ---------------------------------------------------------------------------
module fcache_ctrl #(
  parameter int W     = 16,
  parameter int NREGS = 15,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         save_req,
  input  logic                         restore_req,
  input  logic [W*NREGS-1:0]           fcOut,
  output logic [W*NREGS-1:0]           fcIn,
  output logic                         restore,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int FRAME_W = W * NREGS;
  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(NREGS);
  localparam int ADDR_W  = $clog2(DEPTH * NREGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_READ,
    S_LOAD,
    S_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DEPTH_W-1:0]   sp_q, sp_d;
  logic [FRAME_W-1:0]   snap_q, snap_d;
  logic [FRAME_W-1:0]   stage_q, stage_d;
  logic [FRAME_W-1:0]   fcin_q, fcin_d;
  logic                 restore_q, restore_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic [W-1:0]         mem [DEPTH*NREGS];
  logic [W-1:0]         rd_data_q;
  logic                 mem_we;
  logic [DEPTH_W-1:0]   frame_sel;
  logic [ADDR_W-1:0]    mem_addr;

  // Frame base plus word offset; frame_sel picks sp (push) or sp-1 (pop).
  assign mem_addr = ADDR_W'(frame_sel) * ADDR_W'(NREGS) + ADDR_W'(idx_q);

  // NOTE: the stack RAM has no reset; its contents are meaningless until
  // written, and resetting it would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= snap_q[W-1:0];
    end
    if (state_q == S_READ) begin
      rd_data_q <= mem[mem_addr];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    sp_d      = sp_q;
    snap_d    = snap_q;
    stage_d   = stage_q;
    fcin_d    = fcin_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    frame_sel = sp_q;

    unique case (state_q)
      S_IDLE: begin
        // save has priority; a simultaneous restore_req is simply dropped
        if (save_req) begin
          if (sp_q == DEPTH_W'(DEPTH)) begin
            ovf_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            snap_d  = fcOut;
            idx_d   = '0;
            state_d = S_SAVE;
          end
        end else if (restore_req) begin
          if (sp_q == '0) begin
            unf_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            idx_d   = '0;
            state_d = S_READ;
          end
        end
      end

      S_SAVE: begin
        // Snapshot is shifted down so the word being written is always [W-1:0].
        mem_we = 1'b1;
        snap_d = snap_q >> W;
        if (idx_q == IDX_W'(NREGS - 1)) begin
          sp_d    = sp_q + DEPTH_W'(1);
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_READ: begin
        frame_sel = sp_q - DEPTH_W'(1);
        // Read data lags the address by one cycle, so the word arriving while
        // idx is k belongs to slot k-1. Words enter at the top and shift down.
        if (idx_q != '0) begin
          stage_d = {rd_data_q, stage_q[FRAME_W-1:W]};
        end
        if (idx_q == IDX_W'(NREGS - 1)) begin
          state_d = S_LOAD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_LOAD: begin
        // Last word (slot 14) joins the staged words on the way into fcIn.
        fcin_d  = {rd_data_q, stage_q[FRAME_W-1:W]};
        sp_d    = sp_q - DEPTH_W'(1);
        state_d = S_FIN;
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are registered so restore coincides with the new fcIn value.
  assign restore_d = (state_q == S_LOAD);
  assign done_d    = (state_q == S_FIN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      sp_q      <= '0;
      snap_q    <= '0;
      stage_q   <= '0;
      fcin_q    <= '0;
      restore_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sp_q      <= sp_d;
      snap_q    <= snap_d;
      stage_q   <= stage_d;
      fcin_q    <= fcin_d;
      restore_q <= restore_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign fcIn      = fcin_q;
  assign restore   = restore_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign depth     = sp_q;
  assign busy      = (state_q == S_SAVE) || (state_q == S_READ) ||
                     (state_q == S_LOAD);

endmodule

// File: tb/tb_fcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fcache_ctrl -- directed, table-driven bench for fcache_ctrl.
// Each table record is one request with its hand-computed outcome; a few
// multi-cycle corner cases (reset hold, reset mid-save) are written inline.
// ---------------------------------------------------------------------------
module tb_fcache_ctrl;

  localparam int W     = 16;
  localparam int NREGS = 15;
  localparam int DEPTH = 8;
  localparam int FW    = W * NREGS;

  logic                        clk;
  logic                        reset;
  logic                        save_req;
  logic                        restore_req;
  logic [FW-1:0]               fcOut;
  logic [FW-1:0]               fcIn;
  logic                        restore;
  logic                        busy;
  logic                        done;
  logic                        overflow;
  logic                        underflow;
  logic [$clog2(DEPTH+1)-1:0]  depth;

  fcache_ctrl #(.W(W), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .save_req    (save_req),
    .restore_req (restore_req),
    .fcOut       (fcOut),
    .fcIn        (fcIn),
    .restore     (restore),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .underflow   (underflow),
    .depth       (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_SAVE, OP_RESTORE, OP_BOTH} op_e;

  typedef struct {
    op_e         op;
    int          kind;       // fcOut pattern presented with the request
    logic [15:0] base;
    bit          mid;        // raise restore_req in the middle of the sequence
    int          exp_depth;
    bit          exp_ovf;
    bit          exp_unf;
    bit          exp_rest;   // a restore strobe is expected
    int          exp_kind;   // expected fcIn pattern when exp_rest
    logic [15:0] exp_base;
    int          exp_lat;    // cycle of done, accepting edge = cycle 0
    int          exp_busy;   // number of sampled cycles with busy high
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [FW-1:0] last_fcin;
  vec_t vecs[$];

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // kind 0: f_k = base+k, kind 1: f_k = base-k, kind 2: every word = base
  function automatic logic [FW-1:0] make_frame(input int kind,
                                               input logic [15:0] base);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NREGS; k++) begin
      case (kind)
        0:       f[W*k +: W] = base + 16'(k);
        1:       f[W*k +: W] = base - 16'(k);
        default: f[W*k +: W] = base;
      endcase
    end
    return f;
  endfunction

  function automatic vec_t save_v(input op_e op, input int kind,
                                  input logic [15:0] base, input bit mid,
                                  input int d, input bit o, input bit u);
    vec_t v;
    v.op = op; v.kind = kind; v.base = base; v.mid = mid;
    v.exp_depth = d; v.exp_ovf = o; v.exp_unf = u;
    v.exp_rest = 1'b0; v.exp_kind = 0; v.exp_base = '0;
    v.exp_lat = 16; v.exp_busy = 15;
    return v;
  endfunction

  function automatic vec_t rest_v(input int ekind, input logic [15:0] ebase,
                                  input int d, input bit o, input bit u);
    vec_t v;
    v.op = OP_RESTORE; v.kind = 2; v.base = 16'hFFFF; v.mid = 1'b0;
    v.exp_depth = d; v.exp_ovf = o; v.exp_unf = u;
    v.exp_rest = 1'b1; v.exp_kind = ekind; v.exp_base = ebase;
    v.exp_lat = 17; v.exp_busy = 16;
    return v;
  endfunction

  function automatic vec_t err_v(input op_e op, input int d, input bit o,
                                 input bit u);
    vec_t v;
    v.op = op; v.kind = 2; v.base = 16'hDEAD; v.mid = 1'b0;
    v.exp_depth = d; v.exp_ovf = o; v.exp_unf = u;
    v.exp_rest = 1'b0; v.exp_kind = 0; v.exp_base = '0;
    v.exp_lat = 1; v.exp_busy = 0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one request for one cycle, then follow it until done (bounded).
  task automatic run_op(input vec_t v, input int n);
    int done_at;
    int rest_at;
    int busy_n;
    logic [FW-1:0] got_fcin;
    string tag;
    done_at  = -1;
    rest_at  = -1;
    busy_n   = 0;
    got_fcin = '0;
    tag      = $sformatf("v%0d", n);

    fcOut       = make_frame(v.kind, v.base);
    save_req    = (v.op == OP_SAVE) || (v.op == OP_BOTH);
    restore_req = (v.op == OP_RESTORE) || (v.op == OP_BOTH);
    tick();                          // accepting edge: cycle 0 sampled here
    save_req    = 1'b0;
    restore_req = 1'b0;
    fcOut       = '1;                // must not leak into a saved frame

    for (int c = 0; c <= 40; c++) begin
      if (c > 0) tick();
      if (busy) busy_n++;
      if (restore) begin
        rest_at  = c;
        got_fcin = fcIn;
      end
      if (done) begin
        done_at = c;
        break;
      end
      if (v.mid) restore_req = (c == 5) || (c == 6);
    end
    restore_req = 1'b0;

    check({tag, " done_lat"}, 256'(done_at), 256'(v.exp_lat));
    check({tag, " restore_at"}, 256'(rest_at), 256'(v.exp_rest ? 16 : -1));
    if (v.exp_rest) begin
      last_fcin = make_frame(v.exp_kind, v.exp_base);
      check({tag, " restored_frame"}, 256'(got_fcin), 256'(last_fcin));
    end
    check({tag, " fcin_hold"}, 256'(fcIn), 256'(last_fcin));
    check({tag, " depth"}, 256'(depth), 256'(v.exp_depth));
    check({tag, " overflow"}, 256'(overflow), 256'(v.exp_ovf));
    check({tag, " underflow"}, 256'(underflow), 256'(v.exp_unf));
    check({tag, " busy_cycles"}, 256'(busy_n), 256'(v.exp_busy));
    tick();
    check({tag, " done_pulse"}, 256'(done), 256'(0));
  endtask

  initial begin
    int done_seen;

    // Stimulus table: round trip, LIFO, overflow/drain/underflow, contention.
    vecs.push_back(save_v(OP_SAVE, 0, 16'h0100, 0, 1, 0, 0));
    vecs.push_back(rest_v(0, 16'h0100, 0, 0, 0));
    vecs.push_back(save_v(OP_SAVE, 0, 16'h0000, 0, 1, 0, 0));   // frame A
    vecs.push_back(save_v(OP_SAVE, 1, 16'h000E, 0, 2, 0, 0));   // frame B
    vecs.push_back(rest_v(1, 16'h000E, 1, 0, 0));
    vecs.push_back(rest_v(0, 16'h0000, 0, 0, 0));
    for (int i = 1; i <= DEPTH; i++)
      vecs.push_back(save_v(OP_SAVE, 0, 16'(i << 12), 0, i, 0, 0));
    vecs.push_back(err_v(OP_SAVE, DEPTH, 1, 0));
    for (int i = DEPTH; i >= 1; i--)
      vecs.push_back(rest_v(0, 16'(i << 12), i - 1, 1, 0));
    vecs.push_back(err_v(OP_RESTORE, 0, 1, 1));
    vecs.push_back(save_v(OP_SAVE, 0, 16'h0A00, 0, 1, 1, 1));
    vecs.push_back(save_v(OP_BOTH, 0, 16'h0B00, 0, 2, 1, 1));
    vecs.push_back(save_v(OP_SAVE, 0, 16'h0C00, 1, 3, 1, 1));
    vecs.push_back(rest_v(0, 16'h0C00, 2, 1, 1));
    vecs.push_back(rest_v(0, 16'h0B00, 1, 1, 1));
    vecs.push_back(rest_v(0, 16'h0A00, 0, 1, 1));

    // Reset with save_req held high: nothing may start.
    reset       = 1'b1;
    save_req    = 1'b1;
    restore_req = 1'b0;
    fcOut       = make_frame(0, 16'h0100);
    last_fcin   = '0;
    repeat (3) tick();
    check("rst fcin", 256'(fcIn), 256'(0));
    check("rst depth", 256'(depth), 256'(0));
    check("rst busy", 256'(busy), 256'(0));
    check("rst done", 256'(done), 256'(0));
    check("rst restore", 256'(restore), 256'(0));
    check("rst overflow", 256'(overflow), 256'(0));
    check("rst underflow", 256'(underflow), 256'(0));
    reset    = 1'b0;
    save_req = 1'b0;
    tick();
    check("post_rst busy", 256'(busy), 256'(0));
    check("post_rst depth", 256'(depth), 256'(0));

    foreach (vecs[i]) run_op(vecs[i], i);

    // Reset on cycle 7 of a SAVE with one frame already stored.
    run_op(save_v(OP_SAVE, 1, 16'h5000, 0, 1, 1, 1), 100);
    fcOut    = make_frame(0, 16'h7700);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    check("midrst busy_before", 256'(busy), 256'(1));
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    last_fcin = '0;
    check("midrst busy", 256'(busy), 256'(0));
    check("midrst depth", 256'(depth), 256'(0));
    check("midrst done", 256'(done), 256'(0));
    check("midrst fcin", 256'(fcIn), 256'(0));
    check("midrst overflow", 256'(overflow), 256'(0));
    check("midrst underflow", 256'(underflow), 256'(0));
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("midrst no_activity", 256'(done_seen), 256'(0));
    run_op(err_v(OP_RESTORE, 0, 0, 1), 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcache_ctrl.md
Name: fcache_ctrl

Overview:
- Frame-cache controller for the register management system.
- Saves the 240-bit f-register bank (f0–f14) onto an internal LIFO frame stack on a call, and restores it on a return.
- Frames are serialized into a 16-bit-wide stack memory, one word per cycle.
- Sits between the main control FSM (save_req/restore_req handshake) and the rms fcOut/fcIn/restore ports.

Parameters:
- W, 16, register width in bits.
- NREGS, 15, f-registers per frame; frame width = W*NREGS.
- DEPTH, 8, maximum frames held; stack memory size = DEPTH*NREGS words.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- save_req  input  1  request to push fcOut; sampled only in IDLE.
- restore_req  input  1  request to pop a frame into fcIn; sampled only in IDLE.
- fcOut  input  W*NREGS  live f-register bank from rms; word k = fcOut[W*k+W-1:W*k] = f_k.
- fcIn  output  W*NREGS  restored frame to rms, same word layout; registered.
- restore  output  1  one-cycle strobe to rms; fcIn is valid while high.
- busy  output  1  high while a SAVE/READ/LOAD sequence is in progress.
- done  output  1  one-cycle pulse when an accepted request finishes (including error completions).
- overflow  output  1  sticky error: save attempted with the stack full.
- underflow  output  1  sticky error: restore attempted with the stack empty.
- depth  output  clog2(DEPTH+1)  current number of stored frames.

Behaviour:
- Reset, applied on any clock edge including mid-sequence, forces:
  - state = IDLE, sp/depth = 0, fcIn = 0;
  - restore = busy = done = overflow = underflow = 0.
  - Stack memory contents are not cleared; treat them as don't-care.
- States: IDLE, SAVE, READ, LOAD, FIN.
- IDLE:
  - save_req=1 and depth<DEPTH: snapshot fcOut into an internal frame register and go to SAVE with idx=0. Later fcOut changes do not affect the saved frame.
  - save_req=1 and depth==DEPTH: set overflow and go to FIN. No memory write; depth unchanged.
  - else restore_req=1 and depth>0: go to READ with idx=0.
  - else restore_req=1 and depth==0: set underflow and go to FIN. fcIn unchanged; no restore strobe.
  - Both requests high: save wins; restore_req is dropped and must be re-presented.
- SAVE (15 cycles):
  - Each cycle write snapshot word idx to address sp*NREGS+idx, then idx++.
  - After the idx=14 write: sp++ and go to FIN.
- READ (15 cycles):
  - Each cycle issue a read of address (sp-1)*NREGS+idx. Memory read latency is exactly 1 cycle.
  - Each returned word is placed into fcIn-staging slot idx-1.
  - After issuing idx=14, go to LOAD.
- LOAD (1 cycle):
  - Capture the last word (slot 14).
  - Copy the staging register to fcIn, sp--, assert restore=1 for this cycle only, then go to FIN.
  - fcIn holds this value until the next LOAD or reset.
- FIN (1 cycle): done=1, then go to IDLE.
- busy=1 in SAVE, READ and LOAD; busy=0 in IDLE and FIN.
- Requests arriving while not in IDLE are ignored (no queueing).
- Latency, counting the accepting edge as edge 0:
  - save: done high in cycle 16;
  - restore: restore high in cycle 16, done high in cycle 17;
  - error completion: done high in cycle 1.
- Ordering is LIFO: restore always returns the most recently saved, not-yet-restored frame.
- overflow and underflow stay set until reset. They do not block later legal operations.
- The stack memory is an inferred single-port synchronous RAM with W-bit words.

Test Plan:
- Reset → fcIn=0, depth=0, busy=done=restore=overflow=underflow=0. Hold save_req=1 during reset → no save occurs.
- Round trip:
  - fcOut with f_k = 0x0100+k, pulse save_req → busy for 15 cycles, done at cycle 16, depth=1.
  - Then change fcOut to all 0xFFFF and pulse restore_req → restore strobe at cycle 16 with fcIn word k = 0x0100+k, done at cycle 17, depth=0.
- LIFO:
  - Save frame A (f_k=k), then frame B (f_k=14-k).
  - Two restores return B, then A.
  - depth goes 0→1→2→1→0.
- Overflow and underflow:
  - DEPTH+1 saves → 9th save sets overflow, done at cycle 1, depth stays 8, no memory write.
  - Drain with 8 restores, then one more → underflow=1, no restore strobe, fcIn unchanged.
- Contention:
  - save_req and restore_req together with depth=1 → save executes, depth=2.
  - restore_req asserted mid-SAVE → ignored; depth unchanged after done.
- Reset at cycle 7 of SAVE → IDLE, depth=0, no done. The next restore sets underflow.
